// File: rtl/seg_scan_decoder_if.sv
// Observed 7-segment bus plus the decoded results of the self-test block.
// The display side (or a bench) drives the master view; the decoder uses the slave view.
interface seg_scan_decoder_if;
  logic [7:0]  seg_in;
  logic [7:0]  an_in;
  logic        clr_err;
  logic [31:0] digits;
  logic [7:0]  valid;
  logic        frame_done;
  logic        err;
  logic [2:0]  err_digit;
  logic        stall;

  modport master (
    output seg_in, an_in, clr_err,
    input  digits, valid, frame_done, err, err_digit, stall
  );

  modport slave (
    input  seg_in, an_in, clr_err,
    output digits, valid, frame_done, err, err_digit, stall
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Passive observer of the multiplexed 7-segment display bus. Each digit slot is
// committed once its segment pattern and enable have been steady long enough; the
// pattern is decoded back to its 4-bit display code to rebuild an 8-digit image.
// Patterns outside the display code set decode to F and raise a sticky error.
// A long stretch without any commit marks the display as stalled.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic               clk,
  input logic               rst,
  seg_scan_decoder_if.slave bus
);

  localparam int                IDLE_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]        CNT_MAX   = 8'(STABLE_CYCLES);
  localparam logic [7:0]        CNT_PRE   = 8'(STABLE_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);

  logic [7:0]        s_seg;
  logic [7:0]        s_an;
  logic [7:0]        cnt;
  logic [IDLE_W-1:0] idle;
  logic [7:0]        seen;
  logic [31:0]       digits_q;
  logic [7:0]        valid_q;
  logic              frame_q;
  logic              err_q;
  logic [2:0]        err_digit_q;
  logic              stall_q;

  logic              same;
  logic              one_hot;
  logic              commit;
  logic              full_frame;
  logic [2:0]        idx;
  logic [3:0]        code;
  logic [7:0]        seen_next;

  // Stage-1 sample of the display bus; everything downstream works from these copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg <= 8'h00;
      s_an  <= 8'h00;
    end else begin
      s_seg <= bus.seg_in;
      s_an  <= bus.an_in;
    end
  end

  // Stability test: the value being sampled on this edge against the held sample,
  // so a dwell of STABLE_CYCLES matching edges after the first sample commits it.
  always_comb begin
    same       = (bus.seg_in == s_seg) && (bus.an_in == s_an);
    one_hot    = (s_an != 8'h00) && ((s_an & (s_an - 8'h01)) == 8'h00);
    commit     = same && one_hot && (cnt == CNT_PRE);
    idx        = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (s_an[b]) begin
        idx = 3'(b);
      end
    end
    seen_next  = seen | s_an;
    full_frame = (seen_next == 8'hFF);
  end

  // Decode the seven segment lines back to the display code; DP plays no part.
  always_comb begin
    case (s_seg[7:1])
      7'b1111110: code = 4'h0;
      7'b0110000: code = 4'h1;
      7'b1101101: code = 4'h2;
      7'b1111001: code = 4'h3;
      7'b0110011: code = 4'h4;
      7'b1011011: code = 4'h5;
      7'b1011111: code = 4'h6;
      7'b1110000: code = 4'h7;
      7'b1111111: code = 4'h8;
      7'b1110011: code = 4'h9;
      7'b0000001: code = 4'hA;
      7'b0000000: code = 4'hB;
      7'b0001101: code = 4'hC;
      7'b1001111: code = 4'hD;
      7'b0000101: code = 4'hE;
      default:    code = 4'hF;
    endcase
  end

  // Dwell counter: climbs while a single-digit sample holds, saturates so a long dwell commits only once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'h00;
    end else if (same && one_hot) begin
      if (cnt != CNT_MAX) begin
        cnt <= cnt + 8'h01;
      end
    end else begin
      cnt <= 8'h00;
    end
  end

  // Digit image, frame tracking and stall watchdog; a commit always wins over the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= {8{4'hB}};
      valid_q  <= 8'h00;
      frame_q  <= 1'b0;
      stall_q  <= 1'b0;
      seen     <= 8'h00;
      idle     <= '0;
    end else begin
      frame_q <= 1'b0;
      if (commit) begin
        digits_q[4*idx +: 4] <= code;
        valid_q[idx]         <= 1'b1;
        stall_q              <= 1'b0;
        idle                 <= '0;
        if (full_frame) begin
          frame_q <= 1'b1;
          seen    <= 8'h00;
        end else begin
          seen <= seen_next;
        end
      end else if (idle == IDLE_LAST) begin
        stall_q <= 1'b1;
        valid_q <= 8'h00;
        seen    <= 8'h00;
      end else begin
        idle <= idle + IDLE_ONE;
      end
    end
  end

  // Sticky error flag; an undecodable commit beats a simultaneous clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_digit_q <= 3'd0;
    end else if (commit && (code == 4'hF)) begin
      err_q       <= 1'b1;
      err_digit_q <= idx;
    end else if (bus.clr_err) begin
      err_q <= 1'b0;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.valid      = valid_q;
  assign bus.frame_done = frame_q;
  assign bus.err        = err_q;
  assign bus.err_digit  = err_digit_q;
  assign bus.stall      = stall_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: a constant vector table, hand-written multi-cycle
// sequences and a randomized run, all compared every cycle against a reference
// model built from the display rules (sample run lengths, a code lookup table,
// a set of seen digits and an idle cycle count).
module tb_seg_scan_decoder;

  localparam int STABLE  = 4;
  localparam int TIMEOUT = 16;
  localparam int NV      = 18;

  typedef struct {
    logic [7:0] seg;
    int         idx;
    logic [3:0] code;
    logic       bad;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  seg_scan_decoder_if bus ();

  seg_scan_decoder #(
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int fd_pulses = 0;

  logic [6:0] code_pat [15];
  vec_t       vecs [NV];

  logic [7:0]  m_last_seg;
  logic [7:0]  m_last_an;
  int          m_run;
  logic [31:0] m_digits;
  logic [7:0]  m_valid;
  logic [7:0]  m_seen;
  logic        m_frame;
  logic        m_err;
  logic [2:0]  m_err_digit;
  logic        m_stall;
  int          m_idle;

  // Display code lookup straight from the code table.
  function automatic logic [3:0] ref_decode(input logic [7:0] seg);
    for (int c = 0; c < 15; c++) begin
      if (code_pat[c] == seg[7:1]) return 4'(c);
    end
    return 4'hF;
  endfunction

  function automatic logic [7:0] seg_of(input int c);
    return {code_pat[c], 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_seg  = 8'h00;
    m_last_an   = 8'h00;
    m_run       = 1;
    m_digits    = 32'hBBBBBBBB;
    m_valid     = 8'h00;
    m_seen      = 8'h00;
    m_frame     = 1'b0;
    m_err       = 1'b0;
    m_err_digit = 3'd0;
    m_stall     = 1'b0;
    m_idle      = 0;
  endtask

  // One clock edge of the reference: a value is committed on the edge that sees it
  // for the (STABLE+1)-th time in a row, as long as exactly one digit is enabled.
  task automatic model_edge();
    logic [7:0] seg;
    logic [7:0] an;
    logic       clr;
    logic [3:0] c;
    int         d;
    seg = bus.seg_in;
    an  = bus.an_in;
    clr = bus.clr_err;
    if (seg == m_last_seg && an == m_last_an) m_run++;
    else m_run = 1;
    m_last_seg = seg;
    m_last_an  = an;
    m_frame    = 1'b0;
    if (m_run == STABLE + 1 && $countones(an) == 1) begin
      d = 0;
      for (int b = 0; b < 8; b++) if (an[b]) d = b;
      c = ref_decode(seg);
      m_digits[d*4 +: 4] = c;
      m_valid[d] = 1'b1;
      m_stall    = 1'b0;
      m_idle     = 0;
      m_seen[d]  = 1'b1;
      if (m_seen == 8'hFF) begin
        m_frame = 1'b1;
        m_seen  = 8'h00;
      end
      if (c == 4'hF) begin
        m_err       = 1'b1;
        m_err_digit = 3'(d);
      end else if (clr) begin
        m_err = 1'b0;
      end
    end else begin
      m_idle++;
      if (m_idle >= TIMEOUT) begin
        m_stall = 1'b1;
        m_valid = 8'h00;
        m_seen  = 8'h00;
      end
      if (clr) m_err = 1'b0;
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".digits"},     bus.digits,     m_digits);
    check({tag, ".valid"},      bus.valid,      m_valid);
    check({tag, ".frame_done"}, bus.frame_done, m_frame);
    check({tag, ".err"},        bus.err,        m_err);
    check({tag, ".err_digit"},  bus.err_digit,  m_err_digit);
    check({tag, ".stall"},      bus.stall,      m_stall);
  endtask

  task automatic apply_stimulus(input logic [7:0] seg, input logic [7:0] an, input logic clr);
    bus.seg_in  = seg;
    bus.an_in   = an;
    bus.clr_err = clr;
  endtask

  // Advance one clock, update the reference on the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    @(negedge clk);
    if (bus.frame_done) fd_pulses++;
    check_output("cyc");
  endtask

  // Asynchronous reset pulse issued between edges, with the reset image checked at once.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst.digits",     bus.digits,     32'hBBBBBBBB);
    check("rst.valid",      bus.valid,      32'h0);
    check("rst.frame_done", bus.frame_done, 32'h0);
    check("rst.err",        bus.err,        32'h0);
    check("rst.err_digit",  bus.err_digit,  32'h0);
    check("rst.stall",      bus.stall,      32'h0);
    step();
    rst = 1'b0;
  endtask

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    logic [31:0] dg;
    logic [7:0]  seg;
    logic [7:0]  an;
    int          hold;

    code_pat = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1110011,
                 7'b0000001, 7'b0000000, 7'b0001101, 7'b1001111, 7'b0000101};

    vecs[0]  = '{8'hFC, 0, 4'h0, 1'b0};
    vecs[1]  = '{8'h60, 1, 4'h1, 1'b0};
    vecs[2]  = '{8'hDA, 2, 4'h2, 1'b0};
    vecs[3]  = '{8'hF2, 3, 4'h3, 1'b0};
    vecs[4]  = '{8'h66, 4, 4'h4, 1'b0};
    vecs[5]  = '{8'hB6, 5, 4'h5, 1'b0};
    vecs[6]  = '{8'hBE, 6, 4'h6, 1'b0};
    vecs[7]  = '{8'hE0, 7, 4'h7, 1'b0};
    vecs[8]  = '{8'hFE, 0, 4'h8, 1'b0};
    vecs[9]  = '{8'hE7, 1, 4'h9, 1'b0};
    vecs[10] = '{8'h02, 2, 4'hA, 1'b0};
    vecs[11] = '{8'h00, 3, 4'hB, 1'b0};
    vecs[12] = '{8'h1A, 4, 4'hC, 1'b0};
    vecs[13] = '{8'h9E, 5, 4'hD, 1'b0};
    vecs[14] = '{8'h0A, 6, 4'hE, 1'b0};
    vecs[15] = '{8'h90, 7, 4'hF, 1'b1};
    vecs[16] = '{8'hFF, 0, 4'h8, 1'b0};
    vecs[17] = '{8'h12, 3, 4'hF, 1'b1};

    apply_stimulus(8'h00, 8'h00, 1'b0);
    do_reset();

    // Single digit dwell: commit lands exactly STABLE edges after the first sampling edge.
    apply_stimulus(8'hF2, 8'h01, 1'b0);
    repeat (STABLE) step();
    check("lat.valid_before", bus.valid, 32'h00);
    step();
    check("lat.valid", bus.valid, 32'h01);
    check("lat.digits", bus.digits, 32'hBBBBBBB3);
    step();
    check("lat.hold_digits", bus.digits, 32'hBBBBBBB3);

    // Vector table: every display code and some undecodable patterns.
    do_reset();
    for (int v = 0; v < NV; v++) begin
      apply_stimulus(vecs[v].seg, 8'(1 << vecs[v].idx), 1'b0);
      repeat (STABLE + 1) step();
      dg = bus.digits;
      check("tbl.code", dg[vecs[v].idx*4 +: 4], vecs[v].code);
      if (vecs[v].bad) begin
        check("tbl.err", bus.err, 32'h1);
        check("tbl.err_digit", bus.err_digit, 32'(vecs[v].idx));
        apply_stimulus(vecs[v].seg, 8'(1 << vecs[v].idx), 1'b1);
        step();
        check("tbl.err_cleared", bus.err, 32'h0);
      end
    end

    // Full scan twice: one frame_done pulse per completed frame, on the digit-7 commit.
    do_reset();
    fd_pulses = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < 8; d++) begin
        apply_stimulus(seg_of(d), 8'(1 << d), 1'b0);
        repeat (STABLE) step();
        step();
        check("scan.frame_done", bus.frame_done, 32'(d == 7));
      end
      check("scan.pulses", fd_pulses, 32'(pass + 1));
      check("scan.digits", bus.digits, 32'h76543210);
      check("scan.valid", bus.valid, 32'hFF);
    end

    // Error capture, clear, and clear colliding with a new error commit.
    do_reset();
    apply_stimulus(8'hFF, 8'h04, 1'b0);
    repeat (STABLE + 1) step();
    apply_stimulus(8'h90, 8'h08, 1'b0);
    repeat (STABLE + 1) step();
    dg = bus.digits;
    check("err.dp_ignored", dg[11:8], 32'h8);
    check("err.bad_code", dg[15:12], 32'hF);
    check("err.err", bus.err, 32'h1);
    check("err.err_digit", bus.err_digit, 32'h3);
    apply_stimulus(8'h90, 8'h08, 1'b1);
    step();
    check("err.cleared", bus.err, 32'h0);
    apply_stimulus(8'h90, 8'h20, 1'b0);
    repeat (STABLE) step();
    apply_stimulus(8'h90, 8'h20, 1'b1);
    step();
    check("err.collide_err", bus.err, 32'h1);
    check("err.collide_digit", bus.err_digit, 32'h5);

    // Two digits enabled at once never commit, however long it lasts.
    for (int c = 0; c < 10; c++) begin
      apply_stimulus(seg_of(c / 3), 8'h03, 1'b0);
      step();
    end
    check("glitch.valid", bus.valid, 32'h2C);
    check("glitch.digits", bus.digits, 32'hBBFBF8BB);

    // One-hot enable but the pattern keeps changing faster than the dwell.
    do_reset();
    for (int c = 0; c < 12; c++) begin
      apply_stimulus(seg_of(c / 3), 8'h10, 1'b0);
      step();
    end
    check("bounce.valid", bus.valid, 32'h00);

    // Stall after TIMEOUT idle cycles, cleared by the next commit.
    do_reset();
    apply_stimulus(8'hE6, 8'h02, 1'b0);
    repeat (STABLE + 1) step();
    repeat (TIMEOUT - 1) step();
    check("stall.early", bus.stall, 32'h0);
    step();
    check("stall.set", bus.stall, 32'h1);
    check("stall.valid", bus.valid, 32'h00);
    check("stall.digits", bus.digits, 32'hBBBBBB9B);
    apply_stimulus(8'h66, 8'h40, 1'b0);
    repeat (STABLE) step();
    check("stall.still", bus.stall, 32'h1);
    step();
    check("stall.cleared", bus.stall, 32'h0);
    check("stall.valid_new", bus.valid, 32'h40);
    check("stall.digits_new", bus.digits, 32'hB4BBBB9B);

    // Reset in the middle of a dwell: the partial dwell is discarded.
    do_reset();
    apply_stimulus(8'hB6, 8'h01, 1'b0);
    repeat (STABLE + 1) step();
    check("mid.first_commit", bus.valid, 32'h01);
    apply_stimulus(8'hDA, 8'h10, 1'b0);
    repeat (3) step();
    do_reset();
    repeat (STABLE) step();
    check("mid.no_early", bus.valid, 32'h00);
    step();
    check("mid.valid", bus.valid, 32'h10);
    check("mid.digits", bus.digits, 32'hBBB2BBBB);

    // Randomized traffic against the reference model.
    do_reset();
    for (int t = 0; t < 250; t++) begin
      if ($urandom_range(0, 99) < 80) an = 8'(1 << $urandom_range(0, 7));
      else an = 8'($urandom);
      if ($urandom_range(0, 3) == 0) seg = 8'($urandom);
      else seg = {code_pat[$urandom_range(0, 14)], 1'($urandom)};
      if ($urandom_range(0, 19) == 0) hold = $urandom_range(15, 25);
      else hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        apply_stimulus(seg, an, 1'($urandom_range(0, 9) == 0));
        step();
      end
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
